food_placer: RTL and testbench

// Consumer end of the food-candidate interface. On a placement request, takes (V,H) candidates from the

---
 rtl/food_placer.sv | 139 +++++++++++++
 tb/tb_food_placer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/food_placer.sv
// Food placement engine: validates randomizer candidates against the block grid,
// falls back to a row-major interior scan, and writes BLOCK_FOOD into the first free cell.
module food_placer #(
    parameter int                        GRID_HEIGHT    = 16,
    parameter int                        GRID_WIDTH     = 16,
    parameter int                        BITS_PER_BLOCK = 2,
    parameter logic [BITS_PER_BLOCK-1:0] BLOCK_EMPTY    = 2'b00,
    parameter logic [BITS_PER_BLOCK-1:0] BLOCK_FOOD     = 2'b11,
    parameter int                        MAX_TRIES      = 8,
    localparam int                       VW             = $clog2(GRID_HEIGHT),
    localparam int                       HW             = $clog2(GRID_WIDTH)
) (
    input  logic                      MasterClock,
    input  logic                      ButtonCenter,
    input  logic                      PlaceReq,
    input  logic [VW-1:0]             CandV,
    input  logic [HW-1:0]             CandH,
    output logic [VW-1:0]             RdV,
    output logic [HW-1:0]             RdH,
    input  logic [BITS_PER_BLOCK-1:0] RdBlock,
    output logic                      WrEn,
    output logic [VW-1:0]             WrV,
    output logic [HW-1:0]             WrH,
    output logic [BITS_PER_BLOCK-1:0] WrBlock,
    output logic [VW-1:0]             FoodV,
    output logic [HW-1:0]             FoodH,
    output logic                      FoodValid,
    output logic                      PlaceDone,
    output logic                      Busy,
    output logic                      GridFull
);

    localparam int TW = $clog2(MAX_TRIES + 1);

    typedef enum logic [2:0] {IDLE, TRY, CHECK, SCAN, WRITE, FULL} state_t;

    state_t          state, state_nxt;
    logic [VW-1:0]   addr_v, addr_v_nxt;
    logic [HW-1:0]   addr_h, addr_h_nxt;
    logic [TW-1:0]   try_cnt, try_cnt_nxt;
    logic            cell_ok;
    logic            scan_last;

    // Border rows/columns are walls, so only interior empty cells qualify.
    assign cell_ok = (addr_v >= VW'(1)) && (addr_v <= VW'(GRID_HEIGHT - 2)) &&
                     (addr_h >= HW'(1)) && (addr_h <= HW'(GRID_WIDTH - 2)) &&
                     (RdBlock == BLOCK_EMPTY);
    assign scan_last = (addr_v == VW'(GRID_HEIGHT - 2)) && (addr_h == HW'(GRID_WIDTH - 2));

    always_ff @(posedge MasterClock or negedge ButtonCenter) begin
        if (!ButtonCenter) begin
            state     <= IDLE;
            addr_v    <= '0;
            addr_h    <= '0;
            try_cnt   <= '0;
            FoodV     <= '0;
            FoodH     <= '0;
            FoodValid <= 1'b0;
        end else begin
            state   <= state_nxt;
            addr_v  <= addr_v_nxt;
            addr_h  <= addr_h_nxt;
            try_cnt <= try_cnt_nxt;
            if (state == IDLE && PlaceReq) begin
                FoodValid <= 1'b0;
            end else if (state == WRITE) begin
                FoodV     <= addr_v;
                FoodH     <= addr_h;
                FoodValid <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        addr_v_nxt  = addr_v;
        addr_h_nxt  = addr_h;
        try_cnt_nxt = try_cnt;
        RdV         = addr_v;
        RdH         = addr_h;
        WrV         = addr_v;
        WrH         = addr_h;
        WrEn        = 1'b0;
        PlaceDone   = 1'b0;
        WrBlock     = '0;
        Busy        = 1'b1;
        GridFull    = 1'b0;
        case (state)
            IDLE: begin
                Busy = 1'b0;
                if (PlaceReq) begin
                    try_cnt_nxt = '0;
                    state_nxt   = TRY;
                end
            end
            TRY: begin
                addr_v_nxt = CandV;
                addr_h_nxt = CandH;
                state_nxt  = CHECK;
            end
            CHECK: begin
                if (cell_ok) begin
                    state_nxt = WRITE;
                end else if (try_cnt == TW'(MAX_TRIES - 1)) begin
                    addr_v_nxt = VW'(1);
                    addr_h_nxt = HW'(1);
                    state_nxt  = SCAN;
                end else begin
                    try_cnt_nxt = try_cnt + TW'(1);
                    state_nxt   = TRY;
                end
            end
            SCAN: begin
                if (cell_ok) begin
                    state_nxt = WRITE;
                end else if (scan_last) begin
                    state_nxt = FULL;
                end else if (addr_h == HW'(GRID_WIDTH - 2)) begin
                    addr_h_nxt = HW'(1);
                    addr_v_nxt = addr_v + VW'(1);
                end else begin
                    addr_h_nxt = addr_h + HW'(1);
                end
            end
            WRITE: begin
                WrEn      = 1'b1;
                PlaceDone = 1'b1;
                WrBlock   = BLOCK_FOOD;
                state_nxt = IDLE;
            end
            FULL: begin
                Busy     = 1'b0;
                GridFull = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_food_placer.sv
// Bench for food_placer: a grid memory and candidate table drive the DUT, while a
// timeline model predicts every placement outcome and is compared each cycle.
module tb_food_placer;

    localparam int MT = 8;

    logic       MasterClock = 1'b0;
    logic       ButtonCenter = 1'b0;
    logic       PlaceReq = 1'b0;
    logic [3:0] CandV, CandH, RdV, RdH, WrV, WrH, FoodV, FoodH;
    logic [1:0] RdBlock, WrBlock;
    logic       WrEn, FoodValid, PlaceDone, Busy, GridFull;

    logic [1:0] grid [16][16];
    logic [3:0] ctab_v [64];
    logic [3:0] ctab_h [64];
    int cyc = 0;
    int n_chk = 0, n_fail = 0;

    // Plan for the request in flight: end cycle is WRITE, or the last scan cycle before FULL.
    bit p_act = 0, p_write = 0;
    int p_r = 0, p_end = 0, p_v = 0, p_h = 0;
    int prev_fv = 0, prev_v = 0, prev_h = 0;

    food_placer dut (
        .MasterClock(MasterClock), .ButtonCenter(ButtonCenter), .PlaceReq(PlaceReq),
        .CandV(CandV), .CandH(CandH), .RdV(RdV), .RdH(RdH), .RdBlock(RdBlock),
        .WrEn(WrEn), .WrV(WrV), .WrH(WrH), .WrBlock(WrBlock),
        .FoodV(FoodV), .FoodH(FoodH), .FoodValid(FoodValid),
        .PlaceDone(PlaceDone), .Busy(Busy), .GridFull(GridFull)
    );

    always #5 MasterClock = ~MasterClock;
    always @(posedge MasterClock) cyc <= cyc + 1;

    assign CandV   = ctab_v[cyc[5:0]];
    assign CandH   = ctab_h[cyc[5:0]];
    assign RdBlock = grid[RdV][RdH];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic bit free_cell(input int v, input int h);
        return v >= 1 && v <= 14 && h >= 1 && h <= 14 && grid[v][h] == 2'b00;
    endfunction

    task automatic exp_food(input int c, output int fv, output int v, output int h);
        fv = prev_fv; v = prev_v; h = prev_h;
        if (p_act && p_write && c > p_end) begin
            fv = 1; v = p_v; h = p_h;
        end else if (p_act && c >= p_r + 1) begin
            fv = 0;
        end
    endtask

    // Request with PlaceReq high during cycle r: try t samples the candidate of cycle r+1+2t;
    // scan cell i is examined in cycle r+2*MT+1+i.
    task automatic make_plan(input int r);
        int fv, v, h;
        exp_food(r, fv, v, h);
        prev_fv = fv; prev_v = v; prev_h = h;
        p_act = 1; p_r = r; p_write = 0; p_end = r + 2 * MT + 196;
        for (int t = 0; t < MT && !p_write; t++) begin
            v = ctab_v[(r + 1 + 2 * t) & 63];
            h = ctab_h[(r + 1 + 2 * t) & 63];
            if (free_cell(v, h)) begin
                p_write = 1; p_end = r + 3 + 2 * t; p_v = v; p_h = h;
            end
        end
        for (int i = 0; i < 196 && !p_write; i++) begin
            if (free_cell(1 + i / 14, 1 + i % 14)) begin
                p_write = 1; p_end = r + 2 * MT + 2 + i; p_v = 1 + i / 14; p_h = 1 + i % 14;
            end
        end
    endtask

    task automatic model_reset();
        p_act = 0; p_write = 0; prev_fv = 0; prev_v = 0; prev_h = 0;
    endtask

    always @(negedge MasterClock) begin
        int fv, v, h;
        bit e_wr;
        e_wr = p_act && p_write && cyc == p_end;
        exp_food(cyc, fv, v, h);
        chk("Busy", Busy, int'(p_act && cyc >= p_r + 1 && cyc <= p_end));
        chk("GridFull", GridFull, int'(p_act && !p_write && cyc > p_end));
        chk("WrEn", WrEn, int'(e_wr));
        chk("PlaceDone", PlaceDone, int'(e_wr));
        chk("FoodValid", FoodValid, fv);
        chk("FoodV", FoodV, v);
        chk("FoodH", FoodH, h);
        if (e_wr) begin
            chk("WrV", WrV, p_v);
            chk("WrH", WrH, p_h);
            chk("WrBlock", WrBlock, 3);
            chk("RdV", RdV, p_v);
        end
    end

    // Grid write is applied just after the edge that closes the WRITE cycle.
    task automatic tick();
        bit we;
        logic [3:0] v, h;
        logic [1:0] b;
        @(negedge MasterClock);
        we = WrEn; v = WrV; h = WrH; b = WrBlock;
        @(posedge MasterClock);
        #1;
        if (we) grid[v][h] = b;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) tick();
    endtask

    task automatic request();
        PlaceReq = 1'b1;
        make_plan(cyc);
        tick();
        PlaceReq = 1'b0;
    endtask

    task automatic fill_interior(input logic [1:0] code);
        for (int v = 0; v < 16; v++)
            for (int h = 0; h < 16; h++)
                grid[v][h] = (v >= 1 && v <= 14 && h >= 1 && h <= 14) ? code : 2'b01;
    endtask

    task automatic ctab_snake_cells();
        for (int i = 0; i < 64; i++) begin
            ctab_v[i] = 4'(1 + i % 14);
            ctab_h[i] = 4'(1 + (i * 5) % 14);
            if (ctab_v[i] == 4'd2 && ctab_h[i] == 4'd3) ctab_h[i] = 4'd4;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " outputs"}, int'({RdV, RdH, WrV, WrH, FoodV, FoodH, WrBlock}), 0);
        chk({tag, " flags"}, int'({WrEn, FoodValid, PlaceDone, Busy, GridFull}), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        fill_interior(2'b00);
        for (int i = 0; i < 64; i++) begin ctab_v[i] = 4'd3; ctab_h[i] = 4'd5; end
        repeat (3) tick();
        chk_all_zero("reset");
        ButtonCenter = 1'b1;
        repeat (2) tick();

        // Empty interior, first candidate accepted.
        r = cyc;
        request();
        chk("t1 plan end", p_end - r, 3);
        chk("t1 plan addr", p_v * 16 + p_h, 3 * 16 + 5);
        wait_cyc(p_end + 2);
        chk("t1 grid food", grid[3][5], 3);

        // Border candidate rejected, second try accepted; PlaceReq in CHECK ignored.
        for (int i = 0; i < 64; i++) begin ctab_v[i] = 4'd0; ctab_h[i] = 4'd5; end
        r = cyc;
        ctab_v[(r + 3) & 63] = 4'd4; ctab_h[(r + 3) & 63] = 4'd4;
        request();
        chk("t2 plan end", p_end - r, 5);
        chk("t2 plan addr", p_v * 16 + p_h, 4 * 16 + 4);
        wait_cyc(r + 2);
        PlaceReq = 1'b1;
        tick();
        PlaceReq = 1'b0;
        wait_cyc(p_end + 3);

        // All random tries hit snake, scan finds (2,3).
        fill_interior(2'b01);
        grid[2][3] = 2'b00;
        ctab_snake_cells();
        r = cyc;
        request();
        chk("t3 plan end", p_end - r, 34);
        chk("t3 plan addr", p_v * 16 + p_h, 2 * 16 + 3);
        wait_cyc(p_end + 2);
        chk("t3 grid food", grid[2][3], 3);

        // No free cell anywhere: FULL, sticky, requests ignored.
        fill_interior(2'b01);
        r = cyc;
        request();
        chk("t4 plan kind", int'(p_write), 0);
        chk("t4 full start", p_end + 1 - r, 2 * MT + 196 + 1);
        wait_cyc(p_end + 4);
        PlaceReq = 1'b1;
        repeat (3) tick();
        PlaceReq = 1'b0;
        repeat (3) tick();
        chk("t4 GridFull held", GridFull, 1);

        // Reset out of FULL, then reset again in the middle of a scan.
        ButtonCenter = 1'b0;
        model_reset();
        #1 chk_all_zero("reset from FULL");
        repeat (2) tick();
        ButtonCenter = 1'b1;
        fill_interior(2'b01);
        grid[2][3] = 2'b00;
        ctab_snake_cells();
        tick();
        r = cyc;
        request();
        wait_cyc(r + 20);
        chk("t5 Busy mid-scan", Busy, 1);
        ButtonCenter = 1'b0;
        model_reset();
        #1 chk_all_zero("async reset mid-scan");
        repeat (2) tick();
        ButtonCenter = 1'b1;
        repeat (6) tick();
        chk("t5 no write", grid[2][3], 0);

        // PlaceReq held high: back-to-back placements.
        fill_interior(2'b00);
        for (int i = 0; i < 64; i++) begin
            ctab_v[i] = 4'(1 + i % 14);
            ctab_h[i] = 4'(1 + (i * 3) % 14);
        end
        r = cyc;
        PlaceReq = 1'b1;
        for (int n = 0; n < 6; n++) begin
            make_plan(cyc);
            if (n == 0) chk("t6 first end", p_end - r, 3);
            if (n == 5) begin tick(); PlaceReq = 1'b0; end
            wait_cyc(p_end + 1);
        end
        chk("t6 cadence", int'(cyc - r >= 24), 1);
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
